// File: rtl/cp0_ex_ctrl_pkg.sv
// Shared definitions for the exception/ERET commit controller: MIPS exception
// codes, CP0 register addresses, the default exception vector and FSM states.
package cp0_ex_ctrl_pkg;

   // Exception codes carried down the pipeline to WB (0 = no exception).
   typedef enum logic [4:0] {
      EXC_NONE = 5'h00,
      EXC_ADEL = 5'h04,
      EXC_ADES = 5'h05,
      EXC_SYS  = 5'h08,
      EXC_BP   = 5'h09,
      EXC_RI   = 5'h0a,
      EXC_OV   = 5'h0c
   } excode_e;

   // CP0 register numbers touched by exception entry / ERET.
   typedef enum logic [4:0] {
      CP0_BADVADDR = 5'd8,
      CP0_COUNT    = 5'd9,
      CP0_COMPARE  = 5'd11,
      CP0_STATUS   = 5'd12,
      CP0_CAUSE    = 5'd13,
      CP0_EPC      = 5'd14
   } cp0_reg_e;

   // Exception vector with Status.BEV = 1.
   localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hBFC0_0380;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_REDIR = 2'd2
   } state_e;

   // Value loaded into the 4-bit flush counter on entry to FLUSH. The count
   // is clamped to 1..15 so an out-of-range parameter still yields a sane
   // flush length instead of wrapping.
   function automatic logic [3:0] flush_cnt_init(input int unsigned cycles);
      if (cycles < 1) begin
         return 4'd0;
      end else if (cycles > 15) begin
         return 4'd14;
      end else begin
         return 4'(cycles - 1);
      end
   endfunction

endpackage

// File: rtl/cp0_ex_ctrl.sv
// Exception/ERET commit controller at the WB end of the pipeline. Turns a
// committing exception or ERET into one-cycle CP0 update pulses, flushes the
// younger pipeline stages and offers a fetch redirect (exception vector or
// EPC), holding WB frozen until fetch accepts the new PC.
module cp0_ex_ctrl
   import cp0_ex_ctrl_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEFAULT,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ws_valid,
   input  logic [31:0] ws_pc,
   input  logic [4:0]  ws_excode,
   input  logic        ws_bd,
   input  logic        ws_eret,
   input  logic [31:0] ws_badvaddr,
   input  logic        ws_pc_error,
   input  logic [31:0] cp0_epc,
   output logic        ws_allowin,
   output logic [4:0]  cp0_ex_code,
   output logic        cp0_bd,
   output logic        cp0_eret,
   output logic [31:0] cp0_badvaddr,
   output logic        cp0_pc_error,
   output logic [31:0] cp0_wdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   localparam logic [3:0] FLUSH_CNT_INIT = flush_cnt_init(FLUSH_CYCLES);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_flush_cnt;
   logic [31:0] r_target;
   logic [15:0] r_ex_count;

   logic [4:0]  r_ex_code;
   logic        r_bd;
   logic        r_eret;
   logic [31:0] r_badvaddr;
   logic        r_pc_error;
   logic [31:0] r_wdata;

   logic        w_ex_ev;
   logic        w_er_ev;
   logic        w_allowin;
   logic        w_flush;
   logic        w_redirect_valid;

   // Commit events are only recognised in IDLE; an ERET that also faulted is
   // treated purely as the exception.
   assign w_ex_ev = (r_state == ST_IDLE) && ws_valid && (ws_excode != 5'd0);
   assign w_er_ev = (r_state == ST_IDLE) && ws_valid && ws_eret && !w_ex_ev;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of block ordering.
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived handshake/flush outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      w_state_nxt      = r_state;
      w_allowin        = 1'b0;
      w_flush          = 1'b0;
      w_redirect_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_allowin = 1'b1;
            if (w_ex_ev || w_er_ev) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_flush = 1'b1;
            if (r_flush_cnt == 4'd0) begin
               w_state_nxt = ST_REDIR;
            end
         end
         ST_REDIR: begin
            w_flush          = 1'b1;
            w_redirect_valid = 1'b1;
            if (redirect_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_allowin   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Flush-length counter: loaded as FLUSH is entered, counts down inside it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_flush_cnt <= 4'd0;
      end else if (w_ex_ev || w_er_ev) begin
         r_flush_cnt <= FLUSH_CNT_INIT;
      end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 4'd0)) begin
         r_flush_cnt <= r_flush_cnt - 4'd1;
      end
   end

   // Redirect target captured in the commit cycle (EPC is sampled then, so a
   // later CP0 write cannot move an ERET's return address).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_target <= 32'd0;
      end else if (w_ex_ev) begin
         r_target <= EX_ENTRY;
      end else if (w_er_ev) begin
         r_target <= cp0_epc;
      end
   end

   // CP0 update pulses: cleared every cycle unless a commit loads them, so
   // each pulse and its data last exactly one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ex_code  <= 5'd0;
         r_bd       <= 1'b0;
         r_eret     <= 1'b0;
         r_badvaddr <= 32'd0;
         r_pc_error <= 1'b0;
         r_wdata    <= 32'd0;
      end else begin
         r_ex_code  <= 5'd0;
         r_bd       <= 1'b0;
         r_eret     <= 1'b0;
         r_badvaddr <= 32'd0;
         r_pc_error <= 1'b0;
         r_wdata    <= 32'd0;
         if (w_ex_ev) begin
            r_ex_code  <= ws_excode;
            r_bd       <= ws_bd;
            r_pc_error <= ws_pc_error;
            r_wdata    <= ws_pc;
            // A fetch fault reports the misaligned PC itself as BadVAddr.
            r_badvaddr <= ws_pc_error ? ws_pc : ws_badvaddr;
         end else if (w_er_ev) begin
            r_eret <= 1'b1;
         end
      end
   end

   // Debug statistic: saturating count of committed exceptions.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ex_count <= 16'd0;
      end else if (w_ex_ev && (r_ex_count != 16'hFFFF)) begin
         r_ex_count <= r_ex_count + 16'd1;
      end
   end

   assign ws_allowin     = w_allowin;
   assign flush          = w_flush;
   assign redirect_valid = w_redirect_valid;
   assign redirect_pc    = w_redirect_valid ? r_target : 32'd0;
   assign cp0_ex_code    = r_ex_code;
   assign cp0_bd         = r_bd;
   assign cp0_eret       = r_eret;
   assign cp0_badvaddr   = r_badvaddr;
   assign cp0_pc_error   = r_pc_error;
   assign cp0_wdata      = r_wdata;

endmodule
